// File: rtl/wb_reg_responder.sv
// Pipelined Wishbone B4 register-bank responder with programmable wait states; reg1[7:0] drives the LEDs.
// Optional free-running cycle counter at address NREGS: define WB_REG_RESPONDER_CYCLE_COUNTER_EN.
module wb_reg_responder #(
  parameter int          NREGS       = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hB0B0_0001
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [29:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic [31:0] o_wb_data,
  output logic [7:0]  o_LEDS
);

  localparam int         IDX_W     = $clog2(NREGS);
  localparam bit         NO_WAIT   = (WAIT_STATES == 0);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic        r_stall, w_stall_next;
  logic        r_ack, w_ack_next;
  logic        r_err, w_err_next;
  logic [31:0] r_rdata, w_rdata_next;
  logic [7:0]  r_leds;

  logic        r_we;
  logic [29:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_sel;

  logic [31:0] r_regs [NREGS];

  logic        w_accept, w_latch, w_commit;
  logic        w_c_we;
  logic [29:0] w_c_addr;
  logic [31:0] w_c_data;
  logic [3:0]  w_c_sel;
  logic [IDX_W-1:0] w_idx;
  logic        w_is_id, w_in_bank, w_is_cnt, w_c_err;
  logic [31:0] w_c_rd, w_cur, w_merged, w_cycles;

  assign w_accept = i_wb_cyc & i_wb_stb & ~r_stall;

  // Without wait states the request commits in its accept cycle, straight from the bus.
  assign w_c_we   = NO_WAIT ? i_wb_we   : r_we;
  assign w_c_addr = NO_WAIT ? i_wb_addr : r_addr;
  assign w_c_data = NO_WAIT ? i_wb_data : r_wdata;
  assign w_c_sel  = NO_WAIT ? i_wb_sel  : r_sel;
  assign w_idx    = w_c_addr[IDX_W-1:0];

  assign w_is_id   = (w_c_addr == 30'd0);
  assign w_in_bank = !w_is_id && (w_c_addr < 30'(NREGS));

`ifdef WB_REG_RESPONDER_CYCLE_COUNTER_EN
  logic [31:0] r_cycles;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_cycles <= 32'd0;
    else         r_cycles <= r_cycles + 32'd1;
  end
  assign w_cycles = r_cycles;
  assign w_is_cnt = (w_c_addr == 30'(NREGS));
`else
  assign w_cycles = 32'd0;
  assign w_is_cnt = 1'b0;
`endif

  assign w_c_err = w_is_id ? w_c_we : (w_in_bank ? 1'b0 : (w_is_cnt ? w_c_we : 1'b1));
  assign w_cur   = r_regs[w_idx];

  always_comb begin
    w_c_rd = 32'd0;
    if (w_is_id)        w_c_rd = ID_VALUE;
    else if (w_in_bank) w_c_rd = w_cur;
    else if (w_is_cnt)  w_c_rd = w_cycles;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_merged[8*gi +: 8] = w_c_sel[gi] ? w_c_data[8*gi +: 8] : w_cur[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_stall_next = 1'b0;
    w_latch      = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_WAIT: begin
        // Dropping cyc abandons the pending request without a response.
        if (!i_wb_cyc) begin
          w_state_next = ST_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_state_next = ST_RESP;
          w_commit     = 1'b1;
        end else begin
          w_cnt_next   = r_cnt - 4'd1;
          w_stall_next = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        if (w_accept) begin
          w_latch = 1'b1;
          if (NO_WAIT) begin
            w_state_next = ST_RESP;
            w_commit     = 1'b1;
          end else begin
            w_state_next = ST_WAIT;
            w_cnt_next   = WAIT_LOAD;
            w_stall_next = 1'b1;
          end
        end
      end
    endcase
    w_ack_next   = w_commit & ~w_c_err;
    w_err_next   = w_commit & w_c_err;
    w_rdata_next = (w_commit && !w_c_err && !w_c_we) ? w_c_rd : 32'd0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_stall <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
      r_leds  <= 8'd0;
      r_we    <= 1'b0;
      r_addr  <= 30'd0;
      r_wdata <= 32'd0;
      r_sel   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_stall <= w_stall_next;
      r_ack   <= w_ack_next;
      r_err   <= w_err_next;
      r_rdata <= w_rdata_next;
      r_leds  <= r_regs[1][7:0];
      if (w_latch) begin
        r_we    <= i_wb_we;
        r_addr  <= i_wb_addr;
        r_wdata <= i_wb_data;
        r_sel   <= i_wb_sel;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= 32'd0;
    end else if (w_commit && w_c_we && w_in_bank) begin
      r_regs[w_idx] <= w_merged;
    end
  end

  assign o_wb_stall = r_stall;
  assign o_wb_ack   = r_ack;
  assign o_wb_err   = r_err;
  assign o_wb_data  = r_rdata;
  assign o_LEDS     = r_leds;

endmodule
